// File: rtl/y86_regfile_decode.sv
// Y86-64 decode stage: index decode, 15-entry register file with two write-back
// ports and write-before-read bypass, and a valid/ready output register to execute.
module y86_regfile_decode #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 15,
  parameter int ADDR_W   = 4,
  parameter int RSP_IDX  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [ADDR_W-1:0] rA,
  input  logic [ADDR_W-1:0] rB,
  input  logic              we_e,
  input  logic [ADDR_W-1:0] w_dstE,
  input  logic [DATA_W-1:0] w_valE,
  input  logic              we_m,
  input  logic [ADDR_W-1:0] w_dstM,
  input  logic [DATA_W-1:0] w_valM,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_icode,
  output logic [DATA_W-1:0] out_valA,
  output logic [DATA_W-1:0] out_valB,
  output logic [ADDR_W-1:0] out_srcA,
  output logic [ADDR_W-1:0] out_srcB,
  output logic [ADDR_W-1:0] out_dstE,
  output logic [ADDR_W-1:0] out_dstM
);
  localparam logic [ADDR_W-1:0] RNONE = '1;
  localparam logic [ADDR_W-1:0] RSP   = ADDR_W'(RSP_IDX);
  localparam logic [ADDR_W:0]   NREGS = (ADDR_W+1)'(NUM_REGS);

  typedef struct packed {
    logic [3:0]        icode;
    logic [DATA_W-1:0] vala;
    logic [DATA_W-1:0] valb;
    logic [ADDR_W-1:0] srca;
    logic [ADDR_W-1:0] srcb;
    logic [ADDR_W-1:0] dste;
    logic [ADDR_W-1:0] dstm;
  } bundle_t;

  function automatic logic inrange(input logic [ADDR_W-1:0] i);
    return {1'b0, i} < NREGS;
  endfunction

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [1:0][ADDR_W-1:0]          ridx;
  logic [1:0][DATA_W-1:0]          rval;
  bundle_t                         nxt, cur;

  always_comb begin
    nxt       = '0;
    nxt.icode = icode;
    nxt.srca  = RNONE;
    nxt.srcb  = RNONE;
    nxt.dste  = RNONE;
    nxt.dstm  = RNONE;
    case (icode)
      4'h2, 4'h4, 4'h6, 4'hA: nxt.srca = rA;
      4'h9, 4'hB:             nxt.srca = RSP;
      default: ;
    endcase
    case (icode)
      4'h4, 4'h5, 4'h6:       nxt.srcb = rB;
      4'h8, 4'h9, 4'hA, 4'hB: nxt.srcb = RSP;
      default: ;
    endcase
    case (icode)
      4'h2, 4'h3, 4'h6:       nxt.dste = rB;
      4'h8, 4'h9, 4'hA, 4'hB: nxt.dste = RSP;
      default: ;
    endcase
    case (icode)
      4'h5, 4'hB:             nxt.dstm = rA;
      default: ;
    endcase
    nxt.vala = rval[0];
    nxt.valb = rval[1];
  end

  assign ridx[0] = nxt.srca;
  assign ridx[1] = nxt.srcb;

  // Read ports see this cycle's write-back; M is checked last so it wins a tie.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rval[p] = '0;
      if (inrange(ridx[p])) begin
        rval[p] = regs[ridx[p]];
        if (we_e && w_dstE == ridx[p]) rval[p] = w_valE;
        if (we_m && w_dstM == ridx[p]) rval[p] = w_valM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      if (we_e && inrange(w_dstE)) regs[w_dstE] <= w_valE;
      if (we_m && inrange(w_dstM)) regs[w_dstM] <= w_valM;
    end
  end

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      cur       <= '{icode: 4'h0, vala: '0, valb: '0,
                     srca: RNONE, srcb: RNONE, dste: RNONE, dstm: RNONE};
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      cur       <= nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_icode = cur.icode;
  assign out_valA  = cur.vala;
  assign out_valB  = cur.valb;
  assign out_srcA  = cur.srca;
  assign out_srcB  = cur.srcb;
  assign out_dstE  = cur.dste;
  assign out_dstM  = cur.dstm;
endmodule

// File: tb/tb_y86_regfile_decode.sv
// Scoreboard bench for y86_regfile_decode: stimulus pushes expected bundles
// computed from a post-write register image; a negedge monitor pops and compares.
module tb_y86_regfile_decode;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, in_ready, we_e = 0, we_m = 0, out_valid, out_ready = 0;
  logic [3:0]  icode = 0, rA = 0, rB = 0, w_dstE = 0, w_dstM = 0;
  logic [63:0] w_valE = 0, w_valM = 0, out_valA, out_valB;
  logic [3:0]  out_icode, out_srcA, out_srcB, out_dstE, out_dstM;

  y86_regfile_decode dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .rA(rA), .rB(rB),
    .we_e(we_e), .w_dstE(w_dstE), .w_valE(w_valE),
    .we_m(we_m), .w_dstM(w_dstM), .w_valM(w_valM),
    .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
    .out_valA(out_valA), .out_valB(out_valB), .out_srcA(out_srcA),
    .out_srcB(out_srcB), .out_dstE(out_dstE), .out_dstM(out_dstM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ic;
    logic [63:0] va, vb;
    logic [3:0]  sa, sb, de, dm;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  logic [63:0] rf[16];
  logic        mv = 0;
  int          n_chk = 0, n_fail = 0, n_recv = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [3:0] f_sa(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] f_sb(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] f_de(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] f_dm(input logic [3:0] ic, input logic [3:0] ra);
    return (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
  endfunction

  // One clock of stimulus; the model applies this cycle's writes first, so a
  // read of the updated image is exactly write-before-read with M over E.
  task automatic cycle(input logic iv, input logic [3:0] ic, input logic [3:0] ra,
                       input logic [3:0] rb, input logic wee, input logic [3:0] de,
                       input logic [63:0] ve, input logic wem, input logic [3:0] dm,
                       input logic [63:0] vm, input logic ordy);
    exp_t e;
    logic mrdy;
    @(posedge clk); #1;
    in_valid = iv; icode = ic; rA = ra; rB = rb;
    we_e = wee; w_dstE = de; w_valE = ve;
    we_m = wem; w_dstM = dm; w_valM = vm;
    out_ready = ordy;
    mrdy = !mv || ordy;
    if (wee && de < 4'd15) rf[de] = ve;
    if (wem && dm < 4'd15) rf[dm] = vm;
    if (iv && mrdy) begin
      e.ic = ic;
      e.sa = f_sa(ic, ra); e.sb = f_sb(ic, rb);
      e.de = f_de(ic, rb); e.dm = f_dm(ic, ra);
      e.va = rf[e.sa]; e.vb = rf[e.sb];
      q.push_back(e);
    end
    mv = (iv && mrdy) ? 1'b1 : (ordy ? 1'b0 : mv);
    #1 chk("in_ready", {63'd0, in_ready}, {63'd0, mrdy});
  endtask

  task automatic idle(input logic ordy);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ordy);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_bundle: got icode %h with empty scoreboard", out_icode);
      end else begin
        me = q[0];
        chk("out_icode", {60'd0, out_icode}, {60'd0, me.ic});
        chk("out_valA",  out_valA, me.va);
        chk("out_valB",  out_valB, me.vb);
        chk("out_srcA",  {60'd0, out_srcA}, {60'd0, me.sa});
        chk("out_srcB",  {60'd0, out_srcB}, {60'd0, me.sb});
        chk("out_dstE",  {60'd0, out_dstE}, {60'd0, me.de});
        chk("out_dstM",  {60'd0, out_dstM}, {60'd0, me.dm});
        if (out_ready) begin
          void'(q.pop_front());
          n_recv++;
        end
      end
    end
  end

  initial begin
    int n0;
    foreach (rf[i]) rf[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_srcA", {60'd0, out_srcA}, 64'hF);
    chk("rst_out_dstM", {60'd0, out_dstM}, 64'hF);
    rst_n = 1;

    // write then read
    cycle(0, 0, 0, 0, 1, 3, 64'h1234, 0, 0, 0, 1);
    cycle(1, 6, 3, 3, 0, 0, 0, 0, 0, 0, 1);
    idle(1); @(negedge clk);
    chk("t2_valA", out_valA, 64'h1234);
    chk("t2_valB", out_valB, 64'h1234);
    chk("t2_dstE", {60'd0, out_dstE}, 64'd3);

    // same-cycle bypass, M wins over E
    cycle(1, 4'hB, 4, 0, 1, 4, 64'h10, 1, 4, 64'h20, 1);
    idle(1); @(negedge clk);
    chk("t3_valA", out_valA, 64'h20);
    chk("t3_valB", out_valB, 64'h20);
    cycle(1, 6, 4, 4, 0, 0, 0, 0, 0, 0, 1);
    idle(1); @(negedge clk);
    chk("t3_reg4", out_valA, 64'h20);

    // stall: held bundle must not pick up writes to its sources
    cycle(1, 6, 1, 2, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      cycle(1, 2, 5, 6, 1, 1, 64'hA0 + i, 1, 2, 64'hB0 + i, 0);
    cycle(1, 2, 5, 6, 0, 0, 0, 0, 0, 0, 1);
    idle(1); idle(1);

    // RNONE operand and ignored write to F
    cycle(1, 3, 4'hF, 2, 1, 4'hF, 64'hDEAD, 0, 0, 0, 1);
    idle(1); @(negedge clk);
    chk("t5_valA", out_valA, 64'd0);
    chk("t5_srcA", {60'd0, out_srcA}, 64'hF);
    chk("t5_dstE", {60'd0, out_dstE}, 64'd2);

    // full-rate stream
    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
    n0 = n_recv;
    for (int i = 0; i < 16; i++)
      cycle(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom), 4'($urandom_range(0, 15)),
            {$urandom, $urandom}, 1'($urandom), 4'($urandom_range(0, 15)),
            {$urandom, $urandom}, 1);
    idle(1); @(negedge clk); #1;
    chk("t6_throughput", 64'(n_recv - n0), 64'd16);

    // random traffic with backpressure
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 9) < 8), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom), 4'($urandom_range(0, 15)), {$urandom, $urandom},
            1'($urandom), 4'($urandom_range(0, 15)), {$urandom, $urandom},
            1'($urandom_range(0, 9) < 7));

    // reset while a bundle is stalled
    cycle(1, 6, 3, 3, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    in_valid = 0; we_e = 0; we_m = 0;
    rst_n = 0;
    q.delete(); mv = 0;
    foreach (rf[i]) rf[i] = '0;
    #1;
    chk("t1_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t1_out_valA", out_valA, 64'd0);
    chk("t1_out_dstE", {60'd0, out_dstE}, 64'hF);
    chk("t1_out_icode", {60'd0, out_icode}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    cycle(1, 6, 3, 3, 0, 0, 0, 0, 0, 0, 1);
    idle(1); @(negedge clk);
    chk("t1_reg3_cleared", out_valA, 64'd0);

    for (int i = 0; i < 50 && q.size() > 0; i++) idle(1);
    @(negedge clk); #1;
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
